// File: rtl/dma_lite_seq.sv
// dma_lite_seq: programs one channel of an AXI-DMA style engine through a simple
// register-write port. It runs one transfer per start, waits for the completion
// interrupt or a timeout, then clears the channel status.
//
// Ports:
//   clk, rst       - clock (rising edge) and asynchronous active-high reset
//   start          - run one transfer; sampled only while idle
//   dir            - channel select: 0 = MM2S (base 0x00), 1 = S2MM (base 0x30)
//   addr_lo/hi     - buffer address words, latched at start
//   length         - transfer length in bytes, latched at start
//   irq            - completion interrupt for the selected channel
//   lite_awaddr    - register write byte offset (ADDR_W bits)
//   lite_wdata     - register write data
//   lite_valid     - one-cycle write request pulse
//   lite_end       - write-complete acknowledge from the register master
//   busy           - high from the cycle after start is accepted until done
//   done           - one-cycle completion pulse
//   timeout_err    - qualifies done when the run ended without an irq
module dma_lite_seq #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned ADDR64  = 1,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              dir,
    input  logic [31:0]       addr_lo,
    input  logic [31:0]       addr_hi,
    input  logic [31:0]       length,
    input  logic              irq,
    output logic [ADDR_W-1:0] lite_awaddr,
    output logic [31:0]       lite_wdata,
    output logic              lite_valid,
    input  logic              lite_end,
    output logic              busy,
    output logic              done,
    output logic              timeout_err
);

    localparam logic [31:0] CrData   = 32'h0001_1001;
    localparam logic [31:0] SrData   = 32'h0001_1000;
    localparam logic [31:0] TimeoutW = 32'(TIMEOUT);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StIssue   = 3'd1,
        StWaitEnd = 3'd2,
        StWaitIrq = 3'd3,
        StClear   = 3'd4,
        StWaitClr = 3'd5,
        StDone    = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        StepCr   = 2'd0,
        StepAddr = 2'd1,
        StepMsb  = 2'd2,
        StepLen  = 2'd3
    } step_e;

    state_e      state_q, state_d;
    step_e       step_q, step_d, step_next;
    logic        dir_q, dir_d;
    logic [31:0] addr_lo_q, addr_lo_d;
    logic [31:0] addr_hi_q, addr_hi_d;
    logic [31:0] length_q, length_d;
    logic        irq_pend_q, irq_pend_d;
    logic [31:0] cnt_q, cnt_d;
    logic        tmo_q, tmo_d;

    logic [7:0]  base;
    logic [7:0]  offset;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            step_q     <= StepCr;
            dir_q      <= 1'b0;
            addr_lo_q  <= 32'd0;
            addr_hi_q  <= 32'd0;
            length_q   <= 32'd0;
            irq_pend_q <= 1'b0;
            cnt_q      <= 32'd0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            dir_q      <= dir_d;
            addr_lo_q  <= addr_lo_d;
            addr_hi_q  <= addr_hi_d;
            length_q   <= length_d;
            irq_pend_q <= irq_pend_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
        end
    end

    // Write following the current one; the MSB write is skipped for 32-bit addressing.
    always_comb begin
        step_next = StepLen;
        unique case (step_q)
            StepCr:   step_next = StepAddr;
            StepAddr: step_next = (ADDR64 != 0) ? StepMsb : StepLen;
            StepMsb:  step_next = StepLen;
            default:  step_next = StepLen;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        dir_d      = dir_q;
        addr_lo_d  = addr_lo_q;
        addr_hi_d  = addr_hi_q;
        length_d   = length_q;
        irq_pend_d = irq_pend_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StIssue;
                    step_d     = StepCr;
                    dir_d      = dir;
                    addr_lo_d  = addr_lo;
                    addr_hi_d  = addr_hi;
                    length_d   = length;
                    irq_pend_d = 1'b0;
                    cnt_d      = 32'd0;
                    tmo_d      = 1'b0;
                end
            end
            StIssue, StWaitEnd: begin
                // The engine may fire as soon as LEN is written, before the ack arrives.
                if (step_q == StepLen && irq) begin
                    irq_pend_d = 1'b1;
                end
                if (lite_end) begin
                    if (step_q == StepLen) begin
                        state_d = StWaitIrq;
                        // cnt_q counts cycles elapsed since the LEN ack.
                        cnt_d   = 32'd1;
                    end else begin
                        state_d = StIssue;
                        step_d  = step_next;
                    end
                end else begin
                    state_d = StWaitEnd;
                end
            end
            StWaitIrq: begin
                if (irq_pend_q || irq) begin
                    state_d = StClear;
                end else if (TIMEOUT != 0 && (cnt_q + 32'd1) >= TimeoutW) begin
                    // Clear lands TIMEOUT cycles after the LEN ack.
                    state_d = StClear;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StClear: begin
                state_d = lite_end ? StDone : StWaitClr;
            end
            StWaitClr: begin
                if (lite_end) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign base = dir_q ? 8'h30 : 8'h00;

    always_comb begin
        offset      = 8'h00;
        lite_wdata  = 32'd0;
        lite_valid  = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        timeout_err = 1'b0;

        case (state_q)
            StIdle: begin
                busy = 1'b0;
            end
            StIssue, StWaitEnd: begin
                lite_valid = (state_q == StIssue);
                unique case (step_q)
                    StepCr: begin
                        offset     = base;
                        lite_wdata = CrData;
                    end
                    StepAddr: begin
                        offset     = base + 8'h18;
                        lite_wdata = addr_lo_q;
                    end
                    StepMsb: begin
                        offset     = base + 8'h1C;
                        lite_wdata = addr_hi_q;
                    end
                    default: begin
                        offset     = base + 8'h28;
                        lite_wdata = length_q;
                    end
                endcase
            end
            StWaitIrq: begin
            end
            StClear, StWaitClr: begin
                lite_valid = (state_q == StClear);
                offset     = base + 8'h04;
                lite_wdata = SrData;
            end
            StDone: begin
                done        = 1'b1;
                timeout_err = tmo_q;
            end
            default: begin
                busy = 1'b0;
            end
        endcase

        lite_awaddr = ADDR_W'(offset);
    end

endmodule

// File: tb/tb_dma_lite_seq.sv
module tb_dma_lite_seq;

    localparam int unsigned AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, dir, irq, sel;
    logic [31:0]   addr_lo, addr_hi, length;

    logic [AW-1:0] awaddr_a, awaddr_b;
    logic [31:0]   wdata_a, wdata_b;
    logic          valid_a, valid_b, busy_a, busy_b, done_a, done_b, tmo_a, tmo_b;
    logic          start_a, start_b, irq_a, irq_b, end_a, end_b;

    logic [AW-1:0] m_awaddr;
    logic [31:0]   m_wdata;
    logic          m_valid, m_busy, m_done, m_tmo, m_end;
    logic          end_r = 1'b0;
    int            end_delay = 2;
    int            end_cnt = 0;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    typedef struct {
        logic [AW-1:0] a;
        logic [31:0]   d;
        int            c;
    } wr_t;

    wr_t  log_q[$];
    int   done_cnt = 0;
    int   done_cyc = 0;
    logic last_tmo = 1'b0;

    typedef struct {
        logic          sel;
        logic          dir;
        logic [31:0]   lo, hi, len;
        int            end_d;
        int            irq_d;
        int            nw;
        logic [AW-1:0] ea[5];
        logic [31:0]   ed[5];
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    // dut_a: 64-bit addressing, short timeout. dut_b: 32-bit addressing, no timeout.
    dma_lite_seq #(.ADDR_W(AW), .ADDR64(1), .TIMEOUT(16)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .dir(dir), .addr_lo(addr_lo),
        .addr_hi(addr_hi), .length(length), .irq(irq_a), .lite_awaddr(awaddr_a),
        .lite_wdata(wdata_a), .lite_valid(valid_a), .lite_end(end_a), .busy(busy_a),
        .done(done_a), .timeout_err(tmo_a)
    );

    dma_lite_seq #(.ADDR_W(AW), .ADDR64(0), .TIMEOUT(0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .dir(dir), .addr_lo(addr_lo),
        .addr_hi(addr_hi), .length(length), .irq(irq_b), .lite_awaddr(awaddr_b),
        .lite_wdata(wdata_b), .lite_valid(valid_b), .lite_end(end_b), .busy(busy_b),
        .done(done_b), .timeout_err(tmo_b)
    );

    assign start_a  = start & ~sel;
    assign start_b  = start & sel;
    assign irq_a    = irq & ~sel;
    assign irq_b    = irq & sel;
    assign m_valid  = sel ? valid_b : valid_a;
    assign m_awaddr = sel ? awaddr_b : awaddr_a;
    assign m_wdata  = sel ? wdata_b : wdata_a;
    assign m_busy   = sel ? busy_b : busy_a;
    assign m_done   = sel ? done_b : done_a;
    assign m_tmo    = sel ? tmo_b : tmo_a;
    // Delay 0 acknowledges in the same cycle as the request.
    assign m_end    = (end_delay == 0) ? m_valid : end_r;
    assign end_a    = m_end & ~sel;
    assign end_b    = m_end & sel;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (m_valid) log_q.push_back('{m_awaddr, m_wdata, cyc});
            if (m_done) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
                last_tmo = m_tmo;
            end
        end
    end

    // Acknowledge responder: lite_end high end_delay cycles after each request.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            end_r = 1'b0;
            if (end_cnt != 0) begin
                end_cnt = end_cnt - 1;
                if (end_cnt == 0) end_r = 1'b1;
            end else if (m_valid && end_delay != 0) begin
                end_cnt = end_delay;
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input int i, input logic s, input logic dr, input logic [31:0] lo,
                           input logic [31:0] hi, input logic [31:0] len, input int ed,
                           input int id, input int nw,
                           input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                           input logic [AW-1:0] a2, input logic [AW-1:0] a3,
                           input logic [AW-1:0] a4,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] d3,
                           input logic [31:0] d4);
        vecs[i].sel   = s;
        vecs[i].dir   = dr;
        vecs[i].lo    = lo;
        vecs[i].hi    = hi;
        vecs[i].len   = len;
        vecs[i].end_d = ed;
        vecs[i].irq_d = id;
        vecs[i].nw    = nw;
        vecs[i].ea[0] = a0; vecs[i].ea[1] = a1; vecs[i].ea[2] = a2;
        vecs[i].ea[3] = a3; vecs[i].ea[4] = a4;
        vecs[i].ed[0] = d0; vecs[i].ed[1] = d1; vecs[i].ed[2] = d2;
        vecs[i].ed[3] = d3; vecs[i].ed[4] = d4;
    endtask

    // Pulse start with the given operands, then scramble the inputs to prove latching.
    task automatic start_run(input logic s, input logic d, input logic [31:0] lo,
                             input logic [31:0] hi, input logic [31:0] len, input int ed);
        @(negedge clk);
        #1;
        log_q.delete();
        done_cnt  = 0;
        sel       = s;
        end_delay = ed;
        dir       = d;
        addr_lo   = lo;
        addr_hi   = hi;
        length    = len;
        start     = 1'b1;
        @(negedge clk);
        #1;
        start   = 1'b0;
        dir     = ~d;
        addr_lo = ~lo;
        addr_hi = ~hi;
        length  = ~len;
    endtask

    // Wait for done; irq pulses irq_d cycles after the LEN request (irq_d <= 0: never).
    task automatic run_wait(input int nw, input int irq_d, input bit repulse, output bit seen);
        int irq_wait;
        bit armed;
        irq_wait = 0;
        armed    = 1'b0;
        seen     = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (done_cnt > 0) begin
                seen = 1'b1;
                break;
            end
            irq   = 1'b0;
            start = repulse && k[0];
            if (irq_wait > 0) begin
                irq_wait--;
                if (irq_wait == 0) irq = 1'b1;
            end
            if (!armed && irq_d > 0 && log_q.size() == nw - 1) begin
                armed    = 1'b1;
                irq_wait = irq_d;
            end
            @(negedge clk);
            #1;
        end
        irq   = 1'b0;
        start = 1'b0;
    endtask

    task automatic run_vec(input int i);
        bit seen;
        start_run(vecs[i].sel, vecs[i].dir, vecs[i].lo, vecs[i].hi, vecs[i].len,
                  vecs[i].end_d);
        run_wait(vecs[i].nw, vecs[i].irq_d, 1'b0, seen);
        chk($sformatf("v%0d done seen", i), 64'(seen), 64'd1);
        repeat (3) @(negedge clk);
        #1;
        chk($sformatf("v%0d done count", i), 64'(done_cnt), 64'd1);
        chk($sformatf("v%0d timeout_err", i), 64'(last_tmo), 64'd0);
        chk($sformatf("v%0d busy idle", i), 64'(m_busy), 64'd0);
        chk($sformatf("v%0d write count", i), 64'(log_q.size()), 64'(vecs[i].nw));
        for (int j = 0; j < vecs[i].nw && j < log_q.size(); j++) begin
            chk($sformatf("v%0d wr%0d addr", i, j), 64'(log_q[j].a), 64'(vecs[i].ea[j]));
            chk($sformatf("v%0d wr%0d data", i, j), 64'(log_q[j].d), 64'(vecs[i].ed[j]));
        end
    endtask

    initial begin
        bit seen;
        rst = 1'b1; sel = 1'b0; start = 1'b0; irq = 1'b0; dir = 1'b0;
        addr_lo = 32'd0; addr_hi = 32'd0; length = 32'd0;

        // sel dir lo hi len end_d irq_d nw, addresses, data
        add_vec(0, 1'b0, 1'b0, 32'h1000_0000, 32'h0, 32'h400, 2, 3, 5,
                10'h00, 10'h18, 10'h1C, 10'h28, 10'h04,
                32'h0001_1001, 32'h1000_0000, 32'h0, 32'h400, 32'h0001_1000);
        add_vec(1, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h1, 32'h20, 1, 5, 5,
                10'h30, 10'h48, 10'h4C, 10'h58, 10'h34,
                32'h0001_1001, 32'hDEAD_BEEF, 32'h1, 32'h20, 32'h0001_1000);
        add_vec(2, 1'b1, 1'b1, 32'h1234_5678, 32'hFFFF_FFFF, 32'h1000, 2, 2, 4,
                10'h30, 10'h48, 10'h58, 10'h34, 10'h00,
                32'h0001_1001, 32'h1234_5678, 32'h1000, 32'h0001_1000, 32'h0);
        add_vec(3, 1'b0, 1'b0, 32'hA5A5_A5A4, 32'hFF, 32'h7, 0, 2, 5,
                10'h00, 10'h18, 10'h1C, 10'h28, 10'h04,
                32'h0001_1001, 32'hA5A5_A5A4, 32'hFF, 32'h7, 32'h0001_1000);
        add_vec(4, 1'b1, 1'b0, 32'h0, 32'h55, 32'hFFFF_FFFF, 3, 4, 4,
                10'h00, 10'h18, 10'h28, 10'h04, 10'h00,
                32'h0001_1001, 32'h0, 32'hFFFF_FFFF, 32'h0001_1000, 32'h0);

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("reset outputs a", 64'({valid_a, awaddr_a, wdata_a, busy_a, done_a, tmo_a}), 64'd0);
        chk("reset outputs b", 64'({valid_b, awaddr_b, wdata_b, busy_b, done_b, tmo_b}), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("idle after reset", 64'({busy_a, valid_a, busy_b, valid_b}), 64'd0);

        for (int i = 0; i < 5; i++) run_vec(i);

        // Timeout: no irq, clear 16 cycles after the LEN ack (LEN ack is 2 after its request)
        start_run(1'b0, 1'b0, 32'h2000_0000, 32'h0, 32'h80, 2);
        run_wait(5, 0, 1'b0, seen);
        chk("tmo done seen", 64'(seen), 64'd1);
        chk("tmo write count", 64'(log_q.size()), 64'd5);
        chk("tmo timeout_err with done", 64'(last_tmo), 64'd1);
        if (log_q.size() == 5) begin
            chk("tmo clear addr", 64'(log_q[4].a), 64'h04);
            chk("tmo clear delay", 64'(log_q[4].c - log_q[3].c), 64'd18);
            chk("tmo done delay", 64'(done_cyc - log_q[4].c), 64'd3);
        end

        // Early irq, one cycle after the LEN request and before its ack
        start_run(1'b0, 1'b1, 32'h3000_0000, 32'h2, 32'h40, 2);
        run_wait(5, 1, 1'b0, seen);
        chk("early irq done seen", 64'(seen), 64'd1);
        chk("early irq timeout_err", 64'(last_tmo), 64'd0);
        chk("early irq write count", 64'(log_q.size()), 64'd5);
        if (log_q.size() == 5) begin
            chk("early irq clear addr", 64'(log_q[4].a), 64'h34);
            chk("early irq clear delay", 64'(log_q[4].c - log_q[3].c), 64'd4);
        end

        // Same-cycle acks with start re-pulsed while busy
        start_run(1'b0, 1'b0, 32'h4000_0000, 32'h3, 32'h10, 0);
        run_wait(5, 2, 1'b1, seen);
        chk("repulse done seen", 64'(seen), 64'd1);
        repeat (20) @(negedge clk);
        #1;
        chk("repulse done count", 64'(done_cnt), 64'd1);
        chk("repulse write count", 64'(log_q.size()), 64'd5);
        chk("repulse busy idle", 64'(busy_a), 64'd0);

        // Reset during WAIT_END of the ADDR write
        start_run(1'b0, 1'b0, 32'h5000_0000, 32'h4, 32'h20, 3);
        for (int k = 0; k < 50 && log_q.size() < 2; k++) begin
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        #1;
        chk("mid busy before rst", 64'(busy_a), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid rst outputs", 64'({valid_a, awaddr_a, wdata_a, busy_a, done_a, tmo_a}), 64'd0);
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        chk("mid rst write count", 64'(log_q.size()), 64'd2);
        chk("mid rst no done", 64'(done_cnt), 64'd0);
        chk("mid rst busy", 64'(busy_a), 64'd0);

        run_vec(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
